clk_div_monitor: RTL and testbench

- Sits directly downstream of the divide-by-6 clock divider and checks its divided output.
- Samples the divided clock as data in the fast `clk` domain, measures high time, low time and period in `clk` cycles, and compares them against expected values.
- Reports lock, per-period mismatch pulses, a sticky error flag and a stuck-clock timeout, for self-check benches and on-chip health status.

---
 rtl/clkdiv_pkg.sv | 14 +
 rtl/clk_div_monitor_edge_det.sv | 24 ++
 rtl/clk_div_monitor.sv | 129 ++++++++++++
 tb/tb_clk_div_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divide-by-6 clock divider, its health monitor
// and their benches.
package clkdiv_pkg;
  localparam int DIV_RATIO = 6;
  localparam int CW_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACQ, ST_TRACK, ST_LOCKED, ST_STUCK
  } mon_state_e;

  function automatic logic within_tol(input int v, input int e, input int t);
    return (v >= e - t) && (v <= e + t);
  endfunction
endpackage

// File: rtl/clk_div_monitor_edge_det.sv
// Two-flop sampler of a clk-synchronous level; flags rising and falling
// transitions one cycle after they are captured.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);
  logic r_d1, r_d2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
    end else begin
      r_d1 <= i_d;
      r_d2 <= r_d1;
    end
  end

  assign o_rise = r_d1 & ~r_d2;
  assign o_fall = ~r_d1 & r_d2;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures high time and period of a divided clock sampled as data and
// reports lock, per-period errors, a sticky error and a stuck-clock state.
module clk_div_monitor
  import clkdiv_pkg::*;
#(
  parameter int EXP_PERIOD = DIV_RATIO,
  parameter int EXP_HIGH   = DIV_RATIO / 2,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 64,
  parameter int CW         = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          div_in,
  input  logic          clr,
  output logic          meas_valid,
  output logic [CW-1:0] meas_period,
  output logic [CW-1:0] meas_high,
  output logic          locked,
  output logic          err,
  output logic          err_sticky,
  output logic          stuck
);
  localparam logic [CW-1:0] SAT = '1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  logic          w_rise, w_fall, w_edge;
  logic [CW-1:0] r_seg, r_hi, r_gcnt, w_gcnt_nxt, w_gcnt_inc, w_period;
  logic [CW:0]   w_sum;
  logic          w_good, w_tmo, w_eval, w_err_ev;
  logic          r_mvalid, r_err, r_sticky;
  logic [CW-1:0] r_mper, r_mhigh;
  mon_state_e    r_state, w_nxt;

  edge_det u_edge (
    .clk   (clk),
    .rstn  (rstn),
    .i_d   (div_in),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  assign w_edge     = w_rise | w_fall;
  assign w_sum      = {1'b0, r_hi} + {1'b0, r_seg};
  assign w_period   = w_sum[CW] ? SAT : w_sum[CW-1:0];
  // A clamped period means the real length is unknown, so it can never pass.
  assign w_good     = (w_period != SAT)
                   && within_tol(int'(w_period), EXP_PERIOD, TOL)
                   && within_tol(int'(r_hi), EXP_HIGH, TOL);
  assign w_tmo      = !w_edge && (r_seg == TMO) && (r_state != ST_IDLE);
  assign w_gcnt_inc = r_gcnt + CW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg <= '0;
      r_hi  <= '0;
    end else begin
      if (w_edge)            r_seg <= CW'(1);
      else if (r_seg != SAT) r_seg <= r_seg + CW'(1);
      if (w_fall)            r_hi  <= r_seg;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_gcnt_nxt = r_gcnt;
    w_eval     = 1'b0;
    w_err_ev   = 1'b0;
    case (r_state)
      ST_IDLE, ST_STUCK: if (w_rise) w_nxt = ST_ACQ;
      ST_ACQ, ST_TRACK, ST_LOCKED: begin
        if (w_rise) begin
          w_eval = 1'b1;
          if (!w_good) begin
            w_gcnt_nxt = '0;
            w_err_ev   = 1'b1;
            w_nxt      = ST_TRACK;
          end else if (r_state != ST_LOCKED) begin
            w_gcnt_nxt = w_gcnt_inc;
            w_nxt      = (int'(w_gcnt_inc) >= LOCK_CNT) ? ST_LOCKED : ST_TRACK;
          end
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
    if (w_tmo) begin
      w_nxt      = ST_STUCK;
      w_gcnt_nxt = '0;
      w_err_ev   = 1'b1;
    end
    // clr drops any same-cycle measurement but still lets err pulse.
    if (clr) begin
      w_nxt      = ST_IDLE;
      w_gcnt_nxt = '0;
      w_eval     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_gcnt   <= '0;
      r_mvalid <= 1'b0;
      r_mper   <= '0;
      r_mhigh  <= '0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_mvalid <= w_eval;
      r_err    <= w_err_ev;
      r_sticky <= clr ? 1'b0 : (r_sticky | w_err_ev);
      if (w_eval) begin
        r_mper  <= w_period;
        r_mhigh <= r_hi;
      end
    end
  end

  assign meas_valid  = r_mvalid;
  assign meas_period = r_mper;
  assign meas_high   = r_mhigh;
  assign err         = r_err;
  assign err_sticky  = r_sticky;
  assign locked      = (r_state == ST_LOCKED);
  assign stuck       = (r_state == ST_STUCK);
endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: period table, hand-written corner sequences and
// random waveforms, all checked each cycle against a run-length model.
module tb_clk_div_monitor;
  import clkdiv_pkg::*;

  localparam int CW = 8;
  localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOCK = 3, M_STUCK = 4;

  logic clk = 1'b0, rstn = 1'b1, div_in = 1'b0, clr = 1'b0;
  logic          mv[2], lk[2], er[2], es[2], st[2];
  logic [CW-1:0] mp[2], mh[2];

  always #5 clk = ~clk;

  clk_div_monitor #(.TOL(0)) u0 (
    .clk(clk), .rstn(rstn), .div_in(div_in), .clr(clr),
    .meas_valid(mv[0]), .meas_period(mp[0]), .meas_high(mh[0]),
    .locked(lk[0]), .err(er[0]), .err_sticky(es[0]), .stuck(st[0]));

  clk_div_monitor #(.TOL(1)) u1 (
    .clk(clk), .rstn(rstn), .div_in(div_in), .clr(clr),
    .meas_valid(mv[1]), .meas_period(mp[1]), .meas_high(mh[1]),
    .locked(lk[1]), .err(er[1]), .err_sticky(es[1]), .stuck(st[1]));

  int total = 0, bad = 0;

  // Reference model: input history plus per-instance lock bookkeeping.
  logic samp[$];
  int   k, last_edge, hi_len;
  int   mode[2], good[2], e_per[2], e_hi[2];
  bit   sticky[2], e_mv[2], e_err[2];
  int   tol[2] = '{0, 1};

  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int apack(input int i);
    return int'({mv[i], mp[i], mh[i], lk[i], er[i], es[i], st[i]});
  endfunction

  function automatic int epack(input int i);
    return int'({e_mv[i], 8'(e_per[i]), 8'(e_hi[i]), mode[i] == M_LOCK,
                 e_err[i], sticky[i], mode[i] == M_STUCK});
  endfunction

  task automatic model_reset();
    samp.delete();
    samp.push_back(1'b0);
    k = 0; last_edge = 0; hi_len = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; good[i] = 0; e_per[i] = 0; e_hi[i] = 0;
      sticky[i] = 0; e_mv[i] = 0; e_err[i] = 0;
    end
  endtask

  // Registered effect at the edge that closes cycle k, given clr at that edge.
  task automatic model_edge(input bit c);
    bit cur, prv, rise, fall, edg, ok;
    int seg, per;
    cur  = samp[k];
    prv  = (k == 0) ? 1'b0 : samp[k-1];
    rise = cur & ~prv;
    fall = ~cur & prv;
    edg  = rise | fall;
    seg  = min255(k - last_edge);
    per  = min255(hi_len + seg);
    for (int i = 0; i < 2; i++) begin
      e_mv[i] = 0; e_err[i] = 0;
      if (rise && (mode[i] == M_ACQ || mode[i] == M_TRACK || mode[i] == M_LOCK)) begin
        ok = (per != 255) && iabs(per - DIV_RATIO) <= tol[i]
             && iabs(hi_len - DIV_RATIO/2) <= tol[i];
        if (!c) begin
          e_mv[i] = 1; e_per[i] = per; e_hi[i] = hi_len;
        end
        if (!ok) begin
          good[i] = 0; e_err[i] = 1; mode[i] = M_TRACK;
        end else if (mode[i] != M_LOCK) begin
          good[i]++;
          mode[i] = (good[i] >= 4) ? M_LOCK : M_TRACK;
        end
      end else if (rise) begin
        mode[i] = M_ACQ;
      end else if (!edg && seg == 64 && mode[i] != M_IDLE) begin
        mode[i] = M_STUCK; e_err[i] = 1; good[i] = 0;
      end
      sticky[i] = c ? 1'b0 : (sticky[i] | e_err[i]);
      if (c) begin
        mode[i] = M_IDLE; good[i] = 0;
      end
    end
    if (fall) hi_len = seg;
    if (edg)  last_edge = k;
    k++;
  endtask

  task automatic step(input bit v, input bit c);
    div_in = v;
    clr    = c;
    @(posedge clk);
    model_edge(c);
    samp.push_back(v);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("cyc%0d_u%0d", k, i), apack(i), epack(i));
  endtask

  task automatic wave(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int j = 0; j < h; j++) step(1'b1, 1'b0);
      for (int j = 0; j < l; j++) step(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk($sformatf("async_rst_u%0d", i), apack(i), 0);
    div_in = 1'b0;
    clr    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int hi, lo;
    bit clr_b, chk;
    int per, high;
    bit err, lock, stk;
  } row_t;

  row_t rows[15];

  initial begin
    #3_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, at, p, h;
    bit e, l;
    rows[0]  = '{3, 3, 0, 0, 0, 0, 0, 0, 0};
    rows[1]  = '{3, 3, 0, 1, 6, 3, 0, 0, 0};
    rows[2]  = '{3, 3, 0, 1, 6, 3, 0, 0, 0};
    rows[3]  = '{3, 3, 0, 1, 6, 3, 0, 0, 0};
    rows[4]  = '{3, 3, 0, 1, 6, 3, 0, 1, 0};
    rows[5]  = '{4, 3, 0, 1, 6, 3, 0, 1, 0};
    rows[6]  = '{3, 3, 0, 1, 7, 4, 1, 0, 1};
    rows[7]  = '{3, 3, 0, 1, 6, 3, 0, 0, 1};
    rows[8]  = '{3, 3, 0, 1, 6, 3, 0, 0, 1};
    rows[9]  = '{3, 3, 0, 1, 6, 3, 0, 0, 1};
    rows[10] = '{2, 4, 0, 1, 6, 3, 0, 1, 1};
    rows[11] = '{2, 4, 0, 1, 6, 2, 1, 0, 1};
    rows[12] = '{3, 3, 0, 1, 6, 2, 1, 0, 1};
    rows[13] = '{3, 3, 1, 0, 0, 0, 0, 0, 0};
    rows[14] = '{3, 3, 0, 1, 6, 3, 0, 0, 0};

    #2 rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("reset_u%0d", i), apack(i), 0);
    rstn = 1'b1;
    model_reset();

    // Period table: the measurement of each row's predecessor lands at j == 1.
    for (int r = 0; r < 15; r++) begin
      seen = 0; at = -1; p = 0; h = 0; e = 0; l = 0;
      if (rows[r].clr_b) begin
        step(1'b0, 1'b1);
        chk("clr_sticky", es[0], 0);
        chk("clr_locked", lk[0], 0);
      end
      for (int j = 0; j < rows[r].hi + rows[r].lo; j++) begin
        step(j < rows[r].hi, 1'b0);
        if (mv[0]) begin
          seen++;
          if (at < 0) begin
            at = j; p = mp[0]; h = mh[0]; e = er[0]; l = lk[0];
          end
        end
      end
      if (rows[r].chk) begin
        chk($sformatf("row%0d_nmeas", r), seen, 1);
        chk($sformatf("row%0d_latency", r), at, 1);
        chk($sformatf("row%0d_period", r), p, rows[r].per);
        chk($sformatf("row%0d_high", r), h, rows[r].high);
        chk($sformatf("row%0d_err", r), e, rows[r].err);
        chk($sformatf("row%0d_locked", r), l, rows[r].lock);
      end else begin
        chk($sformatf("row%0d_nmeas", r), seen, 0);
      end
      chk($sformatf("row%0d_sticky", r), es[0], rows[r].stk);
    end

    // Stuck low after lock: timeout fires when the low segment reaches 64.
    wave(3, 3, 4);
    chk("pre_stuck_lock", lk[0], 1);
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0);
    for (int s = 0; s < 70; s++) begin
      step(1'b0, 1'b0);
      if (s == 64) chk("stuck_early", st[0], 0);
      if (s == 65) begin
        chk("stuck_set", st[0], 1);
        chk("stuck_err", er[0], 1);
        chk("stuck_unlock", lk[0], 0);
      end
      if (s == 66) chk("stuck_err_pulse", er[0], 0);
    end
    step(1'b1, 1'b0);
    chk("stuck_hold", st[0], 1);
    step(1'b1, 1'b0);
    chk("stuck_release", st[0], 0);
    step(1'b1, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b0);
    wave(3, 3, 3);
    chk("relock_early", lk[0], 0);
    wave(3, 3, 1);
    chk("relock", lk[0], 1);

    // Asynchronous reset while locked, then reacquire from IDLE.
    do_reset();
    wave(3, 3, 4);
    chk("reacq_early", lk[0], 0);
    wave(3, 3, 1);
    chk("reacq", lk[0], 1);

    // Period 7 / high 3: only the TOL=1 instance accepts it.
    do_reset();
    wave(3, 4, 6);
    chk("tol1_locked", lk[1], 1);
    chk("tol1_sticky", es[1], 0);
    chk("tol0_locked", lk[0], 0);
    chk("tol0_sticky", es[0], 1);

    // Random waveforms with occasional long gaps and clr pulses.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int hh, ll;
      if ($urandom_range(0, 1) == 0) begin
        hh = 3; ll = 3;
      end else begin
        hh = $urandom_range(1, 8);
        ll = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 8);
      end
      for (int j = 0; j < hh; j++) step(1'b1, $urandom_range(0, 39) == 0);
      for (int j = 0; j < ll; j++) step(1'b0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
